lp_seq_divider: RTL and testbench

//   Iterative restoring divider. It is the inverse of the low-power add/sub/mul unit.
//   It takes a 2*WIDTH dividend, such as a product from the multiplier, and a WIDTH

---
 rtl/lp_seq_divider.sv | 149 ++++++++++++++
 tb/tb_lp_seq_divider.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_seq_divider.sv
// Iterative restoring divider: 2*WIDTH / WIDTH -> 2*WIDTH quotient, WIDTH remainder.
// Optional feature: define LPD_ABORT_EN to add an `abort` input that cancels an operation.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one quotient bit per cycle, MSB first
// DONE  | result presented, waiting for out_ready
module lp_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
`ifdef LPD_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy
);

    localparam int CW = (2 * WIDTH > 2) ? $clog2(2 * WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]     r_rem_out;
    logic                 r_div_zero;

    // r_work starts as the dividend; quotient bits shift in at the LSB as dividend bits leave the MSB
    logic [2*WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH:0]       r_prem;
    logic [CW-1:0]        r_cnt;

    logic                 w_abort;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH:0]       w_prem_next;
    logic [2*WIDTH-1:0]   w_work_next;

`ifdef LPD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Restored remainder is always below the divisor, so its top bit never survives the shift
    assign w_trial     = {r_prem[WIDTH-1:0], r_work[2*WIDTH-1]};
    assign w_diff      = w_trial - {1'b0, r_dvs};
    assign w_ge        = r_prem[WIDTH] | (w_trial >= {1'b0, r_dvs});
    assign w_prem_next = w_ge ? w_diff : w_trial;
    assign w_work_next = {r_work[2*WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_quot      <= '0;
            r_rem_out   <= '0;
            r_div_zero  <= 1'b0;
            r_work      <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (divisor != '0) begin
                            r_work  <= dividend;
                            r_dvs   <= divisor;
                            r_prem  <= '0;
                            r_cnt   <= CNT_LAST;
                            r_state <= CALC;
                        end else begin
                            r_quot      <= '1;
                            r_rem_out   <= dividend[WIDTH-1:0];
                            r_div_zero  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    if (w_abort) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_work <= w_work_next;
                        r_prem <= w_prem_next;
                        if (r_cnt == '0) begin
                            r_quot      <= w_work_next;
                            r_rem_out   <= w_prem_next[WIDTH-1:0];
                            r_div_zero  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_abort || out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign quotient  = r_quot;
    assign remainder = r_rem_out;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_lp_seq_divider.sv
// Directed self-checking bench for lp_seq_divider (WIDTH=8).
// The abort scenario is compiled in only when LPD_ABORT_EN is defined.
module tb_lp_seq_divider;

    localparam int W = 8;
    localparam int LAT = 2 * W;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  dividend;
    logic [W-1:0]    divisor;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  quotient;
    logic [W-1:0]    remainder;
    logic            div_zero;
    logic            busy;
`ifdef LPD_ABORT_EN
    logic            abort;
`endif

    int n_vec;
    int n_err;

    lp_seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
`ifdef LPD_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // status word: {out_valid, in_ready, busy, div_zero, quotient, remainder}
    function automatic logic [4+2*W+W-1:0] status();
        return {out_valid, in_ready, busy, div_zero, quotient, remainder};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for exactly one edge; caller guarantees the divider is idle.
    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges counted after the accept edge until out_valid; -1 on timeout.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00});
        end
        #4;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        start_op(16'd1000, 8'd7);
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL basic_calc_flags: got %b want 001", {out_valid, in_ready, busy});
        end
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want %0d", cyc, LAT);
        end
        n_vec++;
        if (status() !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd142, 8'd6}) begin
            n_err++;
            $display("FAIL basic_result: got %h want %h", status(),
                     {1'b1, 1'b0, 1'b1, 1'b0, 16'd142, 8'd6});
        end
        tick();
        n_vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd142, 8'd6}) begin
            n_err++;
            $display("FAIL basic_retain: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'd142, 8'd6});
        end
    endtask

    task automatic test_edges();
        logic [2*W-1:0] t_dvd [4] = '{16'hFFFF, 16'h00FF, 16'h0000, 16'hFFFF};
        logic [W-1:0]   t_dvs [4] = '{8'hFF,    8'h01,    8'h05,    8'h01};
        logic [2*W-1:0] t_q   [4] = '{16'h0101, 16'h00FF, 16'h0000, 16'hFFFF};
        logic [W-1:0]   t_r   [4] = '{8'h00,    8'h00,    8'h00,    8'h00};
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(t_dvd[i], t_dvs[i]);
            wait_result(cyc);
            n_vec++;
            if (cyc !== LAT || {div_zero, quotient, remainder} !== {1'b0, t_q[i], t_r[i]}) begin
                n_err++;
                $display("FAIL edge_%0d: got lat=%0d dz=%b q=%h r=%h want lat=%0d dz=0 q=%h r=%h",
                         i, cyc, div_zero, quotient, remainder, LAT, t_q[i], t_r[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        out_ready = 1'b1;
        start_op(16'h1234, 8'h00);
        wait_result(cyc);
        n_vec++;
        if (cyc !== 0) begin
            n_err++;
            $display("FAIL divzero_latency: got %0d want 0", cyc);
        end
        n_vec++;
        if (status() !== {1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'h34}) begin
            n_err++;
            $display("FAIL divzero_result: got %h want %h", status(),
                     {1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'h34});
        end
        tick();
        start_op(16'd1000, 8'd7);
        wait_result(cyc);
        n_vec++;
        if ({div_zero, quotient, remainder} !== {1'b0, 16'd142, 8'd6}) begin
            n_err++;
            $display("FAIL divzero_clear: got dz=%b q=%0d r=%0d want dz=0 q=142 r=6",
                     div_zero, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        out_ready = 1'b0;
        start_op(16'd200, 8'd3);
        wait_result(cyc);
        // a competing request held high while the result is stalled
        dividend = 16'd50;
        divisor  = 8'd4;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (status() !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd66, 8'd2}) bad++;
        end
        n_vec++;
        if (cyc !== LAT || bad !== 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got lat=%0d bad_cycles=%0d status=%h want lat=%0d bad_cycles=0",
                     cyc, bad, status(), LAT);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL backpressure_release: got %b want 010", {out_valid, in_ready, busy});
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL backpressure_next_accept: got %b want 001", {out_valid, in_ready, busy});
        end
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT || {quotient, remainder} !== {16'd12, 8'd2}) begin
            n_err++;
            $display("FAIL backpressure_next_result: got lat=%0d q=%0d r=%0d want lat=%0d q=12 r=2",
                     cyc, quotient, remainder, LAT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b1;
        start_op(16'd1000, 8'd7);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_clear: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_op(16'd200, 8'd3);
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT || {div_zero, quotient, remainder} !== {1'b0, 16'd66, 8'd2}) begin
            n_err++;
            $display("FAIL midreset_next: got lat=%0d dz=%b q=%0d r=%0d want lat=%0d dz=0 q=66 r=2",
                     cyc, div_zero, quotient, remainder, LAT);
        end
        tick();
    endtask

`ifdef LPD_ABORT_EN
    task automatic test_abort();
        int cyc;
        int seen;
        out_ready = 1'b1;
        start_op(16'd1000, 8'd7);
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++;
        if (status() !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd66, 8'd2}) begin
            n_err++;
            $display("FAIL abort_calc: got %h want %h", status(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 16'd66, 8'd2});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
        end
        // abort in DONE beats out_ready; abort in IDLE does not block an accept
        start_op(16'h1234, 8'h00);
        abort = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL abort_done: got %b want 010", {out_valid, in_ready, busy});
        end
        start_op(16'h0400, 8'h10);
        abort = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_idle_accept: got %b want 001", {out_valid, in_ready, busy});
        end
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT || {div_zero, quotient, remainder} !== {1'b0, 16'h0040, 8'h00}) begin
            n_err++;
            $display("FAIL abort_next: got lat=%0d dz=%b q=%h r=%h want lat=%0d dz=0 q=0040 r=00",
                     cyc, div_zero, quotient, remainder, LAT);
        end
        tick();
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
`ifdef LPD_ABORT_EN
        abort     = 1'b0;
`endif
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
`ifdef LPD_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
